// File: rtl/dsp_be_mlse_pkg.sv
// Shared types for the MLSE back-end: per-lane ALU result bundle and decision modes.
package dsp_be_mlse_pkg;

    typedef struct packed {
        logic dcomp;
        logic dxp;
        logic dxn;
        logic dpst;
        logic dpre;
    } ari_unit_t;

    typedef enum logic [1:0] {
        MODE_SLICER = 2'd0,
        MODE_DFE    = 2'd1,
        MODE_MLSE   = 2'd2,
        MODE_RSVD   = 2'd3
    } mlse_mode_e;

endpackage

// File: rtl/dsp_be_mlse_dec_lane.sv
// One link of the decision-feedback chain: picks this lane's decision from the
// ALU candidates, using the previous lane's decision where the mode needs it.
module dsp_be_mlse_dec_lane
    import dsp_be_mlse_pkg::*;
(
    input  ari_unit_t  ari,
    input  logic       prev,
    input  mlse_mode_e mode,
    output logic       dec
);

    // Reserved mode falls back to the plain slicer.
    always_comb begin
        dec = ari.dcomp;
        case (mode)
            MODE_DFE:  dec = prev ? ari.dxp : ari.dxn;
            MODE_MLSE: begin
                if (ari.dxp == ari.dxn) begin
                    dec = ari.dxp;
                end else begin
                    dec = prev ? ari.dpst : ari.dpre;
                end
            end
            default:   dec = ari.dcomp;
        endcase
    end

endmodule

// File: rtl/dsp_be_mlse_dec_chain.sv
// Two-stage decision resolver: registers a beat of ALU results, runs the serial
// lane chain with a carry from the previous beat, and keeps a saturating ones count.
module dsp_be_mlse_dec_chain
    import dsp_be_mlse_pkg::*;
#(
    parameter int NumLanes = 16,
    parameter int CntWidth = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_vld,
    input  ari_unit_t [NumLanes-1:0]   i_ari,
    input  logic [1:0]                 i_cfg_mlse_mode,
    input  logic                       i_cnt_clr,
    output logic                       o_vld,
    output logic [NumLanes-1:0]        o_dec,
    output logic [CntWidth-1:0]        o_cnt_ones,
    output logic                       o_cnt_sat
);

    localparam int PopWidth = $clog2(NumLanes + 1);
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic                     s1_vld;
    ari_unit_t [NumLanes-1:0] s1_ari;
    mlse_mode_e               s1_mode;
    logic                     r_prev;
    logic [NumLanes-1:0]      dec;
    logic [PopWidth-1:0]      pop;
    logic [CntWidth:0]        cnt_sum;

    // Mode is captured with the beat so a change lands on a beat boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld  <= 1'b0;
            s1_ari  <= '0;
            s1_mode <= MODE_SLICER;
        end else begin
            s1_vld <= i_vld;
            if (i_vld) begin
                s1_ari  <= i_ari;
                s1_mode <= mlse_mode_e'(i_cfg_mlse_mode);
            end
        end
    end

    for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
        logic lane_prev;
        logic lane_dec;

        if (i == 0) begin : g_first
            assign lane_prev = r_prev;
        end else begin : g_next
            assign lane_prev = gen_lane[i-1].lane_dec;
        end

        dsp_be_mlse_dec_lane u_lane (
            .ari  (s1_ari[i]),
            .prev (lane_prev),
            .mode (s1_mode),
            .dec  (lane_dec)
        );

        assign dec[i] = lane_dec;
    end

    // The carry only advances on valid beats, so idle gaps leave the chain intact.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_vld  <= 1'b0;
            o_dec  <= '0;
            r_prev <= 1'b0;
        end else begin
            o_vld <= s1_vld;
            if (s1_vld) begin
                o_dec  <= dec;
                r_prev <= dec[NumLanes-1];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NumLanes; i++) begin
            pop = pop + PopWidth'(o_dec[i]);
        end
    end

    assign cnt_sum = {1'b0, o_cnt_ones} + (CntWidth + 1)'(pop);

    // Clear wins over accumulation; the carry-out bit of the sum flags overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt_ones <= '0;
            o_cnt_sat  <= 1'b0;
        end else if (i_cnt_clr) begin
            o_cnt_ones <= '0;
            o_cnt_sat  <= 1'b0;
        end else if (o_vld) begin
            if (cnt_sum[CntWidth]) begin
                o_cnt_ones <= CntMax;
                o_cnt_sat  <= 1'b1;
            end else begin
                o_cnt_ones <= cnt_sum[CntWidth-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dsp_be_mlse_dec_chain.sv
// Self-checking bench: a beat-level reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios (4 lanes, 4-bit counter).
module tb_dsp_be_mlse_dec_chain;
    import dsp_be_mlse_pkg::*;

    localparam int NL = 4;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vld = 1'b0;
    ari_unit_t [NL-1:0] ari;
    logic [1:0]        mode = 2'd0;
    logic              clr = 1'b0;
    logic              o_vld;
    logic [NL-1:0]     o_dec;
    logic [CW-1:0]     o_cnt_ones;
    logic              o_cnt_sat;

    logic [NL-1:0] tb_dcomp = '0, tb_dxp = '0, tb_dxn = '0, tb_dpst = '0, tb_dpre = '0;

    int n_vec = 0;
    int n_bad = 0;
    bit started = 1'b0;

    dsp_be_mlse_dec_chain #(.NumLanes(NL), .CntWidth(CW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_vld           (vld),
        .i_ari           (ari),
        .i_cfg_mlse_mode (mode),
        .i_cnt_clr       (clr),
        .o_vld           (o_vld),
        .o_dec           (o_dec),
        .o_cnt_ones      (o_cnt_ones),
        .o_cnt_sat       (o_cnt_sat)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            ari[i] = '{dcomp: tb_dcomp[i], dxp: tb_dxp[i], dxn: tb_dxn[i],
                       dpst: tb_dpst[i], dpre: tb_dpre[i]};
        end
    end

    // Reference model: beats wait in a queue until their output cycle, then the
    // lane rules are applied oldest lane first with the carried decision.
    typedef struct {
        int          due;
        int          md;
        logic [NL-1:0] dcomp, dxp, dxn, dpst, dpre;
    } beat_t;

    beat_t q[$];
    int    edge_no = 0;
    logic  m_vld = 1'b0;
    logic [NL-1:0] m_dec = '0;
    logic  m_prev = 1'b0;
    int    m_cnt = 0;
    logic  m_sat = 1'b0;

    function automatic logic [NL-1:0] decide(beat_t b, logic p_in);
        logic [NL-1:0] r;
        logic p;
        p = p_in;
        for (int i = 0; i < NL; i++) begin
            if (b.md == 1) r[i] = p ? b.dxp[i] : b.dxn[i];
            else if (b.md == 2) r[i] = (b.dxp[i] == b.dxn[i]) ? b.dxp[i] : (p ? b.dpst[i] : b.dpre[i]);
            else r[i] = b.dcomp[i];
            p = r[i];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_vld = 1'b0; m_dec = '0; m_prev = 1'b0; m_cnt = 0; m_sat = 1'b0;
        end else begin
            edge_no++;
            if (clr) begin
                m_cnt = 0; m_sat = 1'b0;
            end else if (m_vld) begin
                if (m_cnt + $countones(m_dec) > CMAX) begin
                    m_cnt = CMAX; m_sat = 1'b1;
                end else begin
                    m_cnt = m_cnt + $countones(m_dec);
                end
            end
            m_vld = 1'b0;
            if (q.size() > 0 && q[0].due == edge_no) begin
                beat_t b;
                b = q.pop_front();
                m_dec = decide(b, m_prev);
                m_prev = m_dec[NL-1];
                m_vld = 1'b1;
            end
            if (vld) begin
                beat_t nb;
                nb.due = edge_no + 1; nb.md = int'(mode);
                nb.dcomp = tb_dcomp; nb.dxp = tb_dxp; nb.dxn = tb_dxn;
                nb.dpst = tb_dpst; nb.dpre = tb_dpre;
                q.push_back(nb);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            checkOutput("model o_vld", 32'(o_vld), 32'(m_vld));
            checkOutput("model o_dec", 32'(o_dec), 32'(m_dec));
            checkOutput("model o_cnt_ones", 32'(o_cnt_ones), 32'(m_cnt));
            checkOutput("model o_cnt_sat", 32'(o_cnt_sat), 32'(m_sat));
        end
    end

    // Called at a falling edge; drives one cycle of inputs and returns at the next.
    task automatic applyStimulus(input logic v, input logic [1:0] md,
                                 input logic [NL-1:0] dc, xp, xn, ps, pr,
                                 input logic c);
        vld = v; mode = md; clr = c;
        tb_dcomp = dc; tb_dxp = xp; tb_dxn = xn; tb_dpst = ps; tb_dpre = pr;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic sendBeat(input logic [1:0] md, input logic [NL-1:0] dc, xp, xn, ps, pr);
        applyStimulus(1'b1, md, dc, xp, xn, ps, pr, 1'b0);
        idle();
        idle();
    endtask

    task automatic expectState(input string tag, input logic v, input logic [NL-1:0] d,
                               input int cnt, input logic sat);
        checkOutput({tag, " vld"}, 32'(o_vld), 32'(v));
        checkOutput({tag, " dec"}, 32'(o_dec), 32'(d));
        checkOutput({tag, " cnt"}, 32'(o_cnt_ones), 32'(cnt));
        checkOutput({tag, " sat"}, 32'(o_cnt_sat), 32'(sat));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        expectState("reset", 1'b0, 4'b0000, 0, 1'b0);

        // Slicer beat: output appears two edges after capture, count one edge later.
        applyStimulus(1'b1, 2'd0, 4'b1111, '0, '0, '0, '0, 1'b0);
        idle();
        expectState("slicer out", 1'b1, 4'b1111, 0, 1'b0);
        idle();
        expectState("slicer cnt", 1'b0, 4'b1111, 4, 1'b0);

        sendBeat(2'd0, 4'b0000, '0, '0, '0, '0);
        expectState("zero beat", 1'b0, 4'b0000, 4, 1'b0);

        sendBeat(2'd1, '0, 4'b0101, 4'b0011, '0, '0);
        expectState("dfe", 1'b0, 4'b0001, 5, 1'b0);

        sendBeat(2'd0, 4'b1000, '0, '0, '0, '0);
        sendBeat(2'd2, '0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        expectState("mlse prev1", 1'b0, 4'b0001, 7, 1'b0);
        sendBeat(2'd2, '0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        expectState("mlse prev0", 1'b0, 4'b0000, 7, 1'b0);

        sendBeat(2'd0, 4'b1000, '0, '0, '0, '0);
        for (int i = 0; i < 5; i++) idle();
        expectState("gap hold", 1'b0, 4'b1000, 8, 1'b0);
        sendBeat(2'd1, '0, 4'b0001, 4'b0000, '0, '0);
        expectState("gap carry", 1'b0, 4'b0001, 9, 1'b0);

        applyStimulus(1'b0, 2'd0, '0, '0, '0, '0, '0, 1'b1);
        expectState("clear", 1'b0, 4'b0001, 0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 4'b1111, '0, '0, '0, '0, 1'b0);
        checkOutput("sat cnt 8", 32'(o_cnt_ones), 32'd8);
        idle();
        checkOutput("sat cnt 12", 32'(o_cnt_ones), 32'd12);
        checkOutput("sat flag low", 32'(o_cnt_sat), 32'd0);
        idle();
        checkOutput("sat cnt 15", 32'(o_cnt_ones), 32'd15);
        checkOutput("sat flag high", 32'(o_cnt_sat), 32'd1);

        applyStimulus(1'b1, 2'd0, 4'b1111, '0, '0, '0, '0, 1'b0);
        idle();
        applyStimulus(1'b1, 2'd0, 4'b1111, '0, '0, '0, '0, 1'b1);
        expectState("clr with beat", 1'b0, 4'b1111, 0, 1'b0);
        idle();
        idle();
        expectState("after clr", 1'b0, 4'b1111, 4, 1'b0);

        // Beat captured into S1, then reset lands before it can reach the output.
        vld = 1'b1; mode = 2'd0; tb_dcomp = 4'b0101;
        @(posedge clk);
        #2;
        rst = 1'b1;
        vld = 1'b0;
        #1;
        expectState("async reset", 1'b0, 4'b0000, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("dropped beat vld", 32'(o_vld), 32'd0);
            idle();
        end
        sendBeat(2'd1, '0, 4'b0000, 4'b1111, '0, '0);
        expectState("post reset prev0", 1'b0, 4'b0101, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
